// File: rtl/avmm_arb_pkg.sv
// Shared types and sizing for the two-requester Avalon-MM arbiter.
//   BURST_W      burstcount width (1..2^(BURST_W-1) beats)
//   MAX_PENDING  outstanding read bursts tracked by the tag FIFO (power of 2)
//   t_arb_state  grant FSM states
//   t_tag        read-response routing tag {requester id, burst length}
package avmm_arb_pkg;

  localparam int BURST_W     = 5;
  localparam int MAX_PENDING = 64;
  localparam int TAG_AW      = $clog2(MAX_PENDING);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WR_BURST = 1'b1
  } t_arb_state;

  typedef struct packed {
    logic               id;
    logic [BURST_W-1:0] len;
  } t_tag;

  // A zero burstcount is illegal; it is handled as a single beat.
  function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

endpackage

// File: rtl/avmm_arb_tag_fifo.sv
// In-order read tag FIFO. Show-ahead head, registered full/empty flags,
// push and pop in the same cycle are both performed.
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   push_i   write tag_i (ignored while full)
//   tag_i    tag to store
//   pop_i    drop the head entry (ignored while empty)
//   head_o   oldest stored tag
//   full_o   MAX_PENDING entries stored
//   empty_o  no entries stored
module avmm_arb_tag_fifo
  import avmm_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  t_tag tag_i,
  input  logic pop_i,
  output t_tag head_o,
  output logic full_o,
  output logic empty_o
);

  localparam logic [TAG_AW:0] FULL_CNT = (TAG_AW+1)'(MAX_PENDING);

  t_tag              mem_q [MAX_PENDING];
  logic [TAG_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_AW:0]   cnt_q, cnt_d;
  logic              full_q, empty_q;
  logic              do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + TAG_AW'(do_push);
    rd_ptr_d = rd_ptr_q + TAG_AW'(do_pop);
    cnt_d    = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (TAG_AW+1)'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - (TAG_AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == FULL_CNT);
      empty_q  <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= tag_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/avmm_rw_arbiter.sv
// Shares one downstream Avalon-MM port between two requesters (rq0, rq1).
// Round-robin per command/burst, write bursts lock the grant to their owner,
// read responses are routed back in order through a tag FIFO.
// Command and response paths are combinational; only arbitration state is held.
//   pClk                 clock, rising edge
//   pck_cp2af_softReset  synchronous active-high reset (shared with downstream)
//   rqN_*                requester N slave-side Avalon-MM port (N = 0, 1)
//   dn_*                 downstream master-side Avalon-MM port
//   err_orphan_rsp       sticky: read beat arrived with no outstanding read
//
// state    | meaning
// IDLE     | arbitrate per command, rr_ptr breaks ties
// WR_BURST | write burst in progress, grant locked to wr_owner
module avmm_rw_arbiter
  import avmm_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
) (
  input  logic                pClk,
  input  logic                pck_cp2af_softReset,
  input  logic [ADDR_W-1:0]   rq0_address,
  input  logic                rq0_read,
  input  logic                rq0_write,
  input  logic [BURST_W-1:0]  rq0_burstcount,
  input  logic [DATA_W-1:0]   rq0_writedata,
  input  logic [DATA_W/8-1:0] rq0_byteenable,
  output logic                rq0_waitrequest,
  output logic [DATA_W-1:0]   rq0_readdata,
  output logic                rq0_readdatavalid,
  input  logic [ADDR_W-1:0]   rq1_address,
  input  logic                rq1_read,
  input  logic                rq1_write,
  input  logic [BURST_W-1:0]  rq1_burstcount,
  input  logic [DATA_W-1:0]   rq1_writedata,
  input  logic [DATA_W/8-1:0] rq1_byteenable,
  output logic                rq1_waitrequest,
  output logic [DATA_W-1:0]   rq1_readdata,
  output logic                rq1_readdatavalid,
  output logic [ADDR_W-1:0]   dn_address,
  output logic                dn_read,
  output logic                dn_write,
  output logic [BURST_W-1:0]  dn_burstcount,
  output logic [DATA_W-1:0]   dn_writedata,
  output logic [DATA_W/8-1:0] dn_byteenable,
  input  logic                dn_waitrequest,
  input  logic [DATA_W-1:0]   dn_readdata,
  input  logic                dn_readdatavalid,
  output logic                err_orphan_rsp
);

  logic rst;
  assign rst = pck_cp2af_softReset;

  t_arb_state         state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic               wr_owner_q, wr_owner_d;
  logic [BURST_W-1:0] wr_left_q, wr_left_d;
  logic [BURST_W-1:0] rd_cnt_q, rd_cnt_d;
  logic               err_q, err_d;

  logic               act0, act1;
  logic               gnt, gnt_vld;
  logic               sel_read, sel_write;
  logic [BURST_W-1:0] sel_bc;
  logic               rd_block, cmd_wait, accept;
  logic               rsp_vld;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  t_tag               fifo_head, push_tag;

  assign act0 = rq0_read | rq0_write;
  assign act1 = rq1_read | rq1_write;

  // State register
  always_ff @(posedge pClk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      wr_owner_q <= 1'b0;
      wr_left_q  <= '0;
      rd_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_owner_q <= wr_owner_d;
      wr_left_q  <= wr_left_d;
      rd_cnt_q   <= rd_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wr_owner_d = wr_owner_q;
    wr_left_d  = wr_left_q;
    rd_cnt_d   = rd_cnt_q;
    err_d      = err_q | (dn_readdatavalid & fifo_empty);
    if (rsp_vld) begin
      rd_cnt_d = fifo_pop ? '0 : rd_cnt_q + BURST_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (dn_write && (eff_burst(sel_bc) != BURST_W'(1))) begin
            state_d    = WR_BURST;
            wr_left_d  = eff_burst(sel_bc) - BURST_W'(1);
            wr_owner_d = gnt;
          end else begin
            rr_ptr_d = ~gnt;
          end
        end
      end
      WR_BURST: begin
        if (accept) begin
          wr_left_d = wr_left_q - BURST_W'(1);
          if (wr_left_q == BURST_W'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = ~wr_owner_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs: grant selection, command mux, response steering
  always_comb begin
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_vld = act0 | act1;
        gnt     = (act0 & act1) ? rr_ptr_q : act1;
      end
      WR_BURST: begin
        gnt_vld = 1'b1;
        gnt     = wr_owner_q;
      end
      default: ;
    endcase

    sel_read      = gnt ? rq1_read       : rq0_read;
    sel_write     = gnt ? rq1_write      : rq0_write;
    sel_bc        = gnt ? rq1_burstcount : rq0_burstcount;
    dn_address    = gnt ? rq1_address    : rq0_address;
    dn_writedata  = gnt ? rq1_writedata  : rq0_writedata;
    dn_byteenable = gnt ? rq1_byteenable : rq0_byteenable;
    dn_burstcount = sel_bc;

    // Reads wait while the tag FIFO is full (even if a pop is in flight this
    // cycle) and are never mixed into a locked write burst.
    rd_block = sel_read & (fifo_full | (state_q == WR_BURST));
    dn_read  = ~rst & gnt_vld & sel_read & ~rd_block;
    dn_write = ~rst & gnt_vld & sel_write;
    cmd_wait = dn_waitrequest | rd_block;

    rq0_waitrequest = rst | ~(gnt_vld & ~gnt) | cmd_wait;
    rq1_waitrequest = rst | ~(gnt_vld &  gnt) | cmd_wait;

    accept    = (dn_read | dn_write) & ~dn_waitrequest;
    fifo_push = dn_read & ~dn_waitrequest;
    push_tag  = '{id: gnt, len: eff_burst(sel_bc)};

    rsp_vld           = ~rst & dn_readdatavalid & ~fifo_empty;
    rq0_readdatavalid = rsp_vld & ~fifo_head.id;
    rq1_readdatavalid = rsp_vld &  fifo_head.id;
    fifo_pop          = rsp_vld & (rd_cnt_q == fifo_head.len - BURST_W'(1));
  end

  assign rq0_readdata   = dn_readdata;
  assign rq1_readdata   = dn_readdata;
  assign err_orphan_rsp = err_q;

  avmm_arb_tag_fifo u_tag_fifo (
    .clk_i   (pClk),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .tag_i   (push_tag),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  a_no_zero_burst: assert property (@(posedge pClk) disable iff (rst)
    (state_q == IDLE && accept) |-> (sel_bc != '0))
    else $error("zero burstcount accepted");

endmodule

// File: tb/tb_avmm_rw_arbiter.sv
// Directed scenarios followed by a randomized run checked against a
// queue-based model of the arbitration and response-routing rules.
module tb_avmm_rw_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int BE_W   = DATA_W / 8;
  localparam int BW     = 5;
  localparam int DEPTH  = 64;

  logic              pClk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rq0_address, rq1_address, dn_address;
  logic              rq0_read, rq0_write, rq1_read, rq1_write;
  logic [BW-1:0]     rq0_burstcount, rq1_burstcount, dn_burstcount;
  logic [DATA_W-1:0] rq0_writedata, rq1_writedata, dn_writedata;
  logic [BE_W-1:0]   rq0_byteenable, rq1_byteenable, dn_byteenable;
  logic              rq0_waitrequest, rq1_waitrequest;
  logic [DATA_W-1:0] rq0_readdata, rq1_readdata, dn_readdata;
  logic              rq0_readdatavalid, rq1_readdatavalid;
  logic              dn_read, dn_write, dn_waitrequest, dn_readdatavalid;
  logic              err_orphan_rsp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pClk = ~pClk;

  avmm_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .pClk(pClk), .pck_cp2af_softReset(rst),
    .rq0_address(rq0_address), .rq0_read(rq0_read), .rq0_write(rq0_write),
    .rq0_burstcount(rq0_burstcount), .rq0_writedata(rq0_writedata),
    .rq0_byteenable(rq0_byteenable), .rq0_waitrequest(rq0_waitrequest),
    .rq0_readdata(rq0_readdata), .rq0_readdatavalid(rq0_readdatavalid),
    .rq1_address(rq1_address), .rq1_read(rq1_read), .rq1_write(rq1_write),
    .rq1_burstcount(rq1_burstcount), .rq1_writedata(rq1_writedata),
    .rq1_byteenable(rq1_byteenable), .rq1_waitrequest(rq1_waitrequest),
    .rq1_readdata(rq1_readdata), .rq1_readdatavalid(rq1_readdatavalid),
    .dn_address(dn_address), .dn_read(dn_read), .dn_write(dn_write),
    .dn_burstcount(dn_burstcount), .dn_writedata(dn_writedata),
    .dn_byteenable(dn_byteenable), .dn_waitrequest(dn_waitrequest),
    .dn_readdata(dn_readdata), .dn_readdatavalid(dn_readdatavalid),
    .err_orphan_rsp(err_orphan_rsp)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    rq0_read = 1'b0; rq0_write = 1'b0; rq1_read = 1'b0; rq1_write = 1'b0;
    dn_waitrequest = 1'b0; dn_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Expects n read beats all routed to requester id.
  task automatic respond(input int n, input bit id, input string tag);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = rand_data();
      dn_readdata = d;
      dn_readdatavalid = 1'b1;
      settle();
      chk({tag, "_rdv0"}, rq0_readdatavalid, !id);
      chk({tag, "_rdv1"}, rq1_readdatavalid, id);
      chk({tag, "_rdata"}, id ? rq1_readdata : rq0_readdata, d);
      tick();
    end
    dn_readdatavalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc, wbeat, n0, n1;
    bit hole;
    logic [DATA_W-1:0] d;
    int exp_id [7];

    rq0_address = '0; rq1_address = '0; rq0_burstcount = 1; rq1_burstcount = 1;
    rq0_writedata = '0; rq1_writedata = '0;
    rq0_byteenable = '1; rq1_byteenable = '1; dn_readdata = '0;
    idle_inputs();
    rst = 1'b1;
    tick(); tick();

    // Reset: outputs forced quiet even with traffic present
    rq0_read = 1'b1; dn_readdatavalid = 1'b1;
    settle();
    chk("rst_dn_read", dn_read, 0);
    chk("rst_dn_write", dn_write, 0);
    chk("rst_wait0", rq0_waitrequest, 1);
    chk("rst_wait1", rq1_waitrequest, 1);
    chk("rst_rdv0", rq0_readdatavalid, 0);
    chk("rst_rdv1", rq1_readdatavalid, 0);
    tick();
    idle_inputs();
    rst = 1'b0;
    tick();
    chk("rst_err", err_orphan_rsp, 0);

    // 1: single rq0 read burst of 4
    rq0_address = 64'h1000; rq0_burstcount = 4; rq0_read = 1'b1;
    settle();
    chk("t1_dn_read", dn_read, 1);
    chk("t1_addr", dn_address, 64'h1000);
    chk("t1_bc", dn_burstcount, 4);
    chk("t1_wait0", rq0_waitrequest, 0);
    chk("t1_wait1", rq1_waitrequest, 1);
    tick();
    rq0_read = 1'b0;
    respond(4, 1'b0, "t1");

    // 2: simultaneous rq0 read / rq1 write after reset, continuously re-issued
    do_reset();
    rq0_address = 64'hA0; rq0_burstcount = 1; rq0_read = 1'b1; rq0_byteenable = '1;
    rq1_address = 64'hB0; rq1_burstcount = 1; rq1_write = 1'b1; rq1_byteenable = '0;
    rq1_writedata = rand_data();
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("t2_addr", dn_address, (i % 2) ? 64'hB0 : 64'hA0);
      chk("t2_dn_read", dn_read, (i % 2) == 0);
      chk("t2_dn_write", dn_write, (i % 2) == 1);
      chk("t2_wait0", rq0_waitrequest, (i % 2) == 1);
      chk("t2_wait1", rq1_waitrequest, (i % 2) == 0);
      chk("t2_be", dn_byteenable, (i % 2) ? BE_W'(0) : {BE_W{1'b1}});
      if (i % 2) chk("t2_wdata", dn_writedata, rq1_writedata);
      tick();
    end
    rq0_read = 1'b0; rq1_write = 1'b0;
    respond(3, 1'b0, "t2");

    // 3: rq1 write burst of 8 locks out a pending rq0 read
    rq1_address = 64'hC0; rq1_burstcount = 8; rq1_write = 1'b1;
    rq1_writedata = DATA_W'(100);
    settle();
    chk("t3_first_write", dn_write, 1);
    chk("t3_first_wait1", rq1_waitrequest, 0);
    tick();
    wbeat = 1;
    rq0_address = 64'hD0; rq0_burstcount = 1; rq0_read = 1'b1;
    cyc = 0;
    while (wbeat < 8 && cyc < 100) begin
      cyc++;
      dn_waitrequest = ($urandom_range(0, 2) == 0);
      hole = (cyc == 3);
      rq1_write = !hole;
      rq1_writedata = DATA_W'(100 + wbeat);
      settle();
      chk("t3_dn_read", dn_read, 0);
      chk("t3_wait0", rq0_waitrequest, 1);
      chk("t3_dn_write", dn_write, !hole);
      chk("t3_wait1", rq1_waitrequest, dn_waitrequest);
      if (!hole) chk("t3_wdata", dn_writedata, DATA_W'(100 + wbeat));
      if (!hole && !dn_waitrequest) wbeat++;
      tick();
    end
    chk("t3_beats", wbeat, 8);
    rq1_write = 1'b0; dn_waitrequest = 1'b0;
    settle();
    chk("t3_rd_after", dn_read, 1);
    chk("t3_rd_addr", dn_address, 64'hD0);
    chk("t3_rd_wait0", rq0_waitrequest, 0);
    tick();
    rq0_read = 1'b0;
    respond(1, 1'b0, "t3");

    // 4: fill the tag FIFO, 65th read stalls until a response arrives
    rq0_read = 1'b1; rq0_burstcount = 1;
    acc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rq0_address = ADDR_W'(i);
      settle();
      if (rq0_waitrequest === 1'b0 && dn_read === 1'b1) acc++;
      tick();
    end
    chk("t4_accepted", acc, DEPTH);
    settle();
    chk("t4_full_wait", rq0_waitrequest, 1);
    chk("t4_full_dnread", dn_read, 0);
    tick();
    dn_readdatavalid = 1'b1;
    settle();
    chk("t4_pop_blocked", rq0_waitrequest, 1);
    chk("t4_pop_rdv", rq0_readdatavalid, 1);
    tick();
    dn_readdatavalid = 1'b0;
    settle();
    chk("t4_freed_wait", rq0_waitrequest, 0);
    chk("t4_freed_read", dn_read, 1);
    tick();
    rq0_read = 1'b0;
    n0 = 0; n1 = 0;
    dn_readdatavalid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      settle();
      if (rq0_readdatavalid === 1'b1) n0++;
      if (rq1_readdatavalid === 1'b1) n1++;
      tick();
    end
    dn_readdatavalid = 1'b0;
    chk("t4_drain0", n0, DEPTH);
    chk("t4_drain1", n1, 0);
    chk("t4_err", err_orphan_rsp, 0);

    // 5: interleaved reads, steering follows issue order; push+pop overlap
    rq0_burstcount = 2; rq0_read = 1'b1;
    settle(); chk("t5_acc_a", rq0_waitrequest, 0); tick(); rq0_read = 1'b0;
    rq1_burstcount = 3; rq1_read = 1'b1;
    settle(); chk("t5_acc_b", rq1_waitrequest, 0); tick(); rq1_read = 1'b0;
    rq0_burstcount = 1; rq0_read = 1'b1;
    settle(); chk("t5_acc_c", rq0_waitrequest, 0); tick(); rq0_read = 1'b0;
    exp_id = '{0, 0, 1, 1, 1, 0, 1};
    for (int i = 0; i < 7; i++) begin
      d = rand_data();
      dn_readdata = d;
      dn_readdatavalid = 1'b1;
      rq1_read = (i == 1);
      rq1_burstcount = 1;
      settle();
      if (i == 1) chk("t5_push_pop_acc", rq1_waitrequest, 0);
      chk("t5_rdv0", rq0_readdatavalid, exp_id[i] == 0);
      chk("t5_rdv1", rq1_readdatavalid, exp_id[i] == 1);
      tick();
    end
    rq1_read = 1'b0; dn_readdatavalid = 1'b0;
    settle();
    chk("t5_err", err_orphan_rsp, 0);

    // 6: orphan beat is flagged and sticky; reset mid write burst
    dn_readdatavalid = 1'b1;
    settle();
    chk("t6_orph_rdv0", rq0_readdatavalid, 0);
    chk("t6_orph_rdv1", rq1_readdatavalid, 0);
    tick();
    dn_readdatavalid = 1'b0;
    chk("t6_err_set", err_orphan_rsp, 1);
    repeat (3) tick();
    chk("t6_err_sticky", err_orphan_rsp, 1);
    rq1_address = 64'hE0; rq1_burstcount = 4; rq1_write = 1'b1;
    tick(); tick();
    rq0_address = 64'hF0; rq0_burstcount = 1; rq0_write = 1'b1;
    settle();
    chk("t6_locked_wait0", rq0_waitrequest, 1);
    rst = 1'b1;
    settle();
    chk("t6_rst_dnwrite", dn_write, 0);
    chk("t6_rst_wait1", rq1_waitrequest, 1);
    tick();
    rst = 1'b0; rq1_write = 1'b0;
    settle();
    chk("t6_err_clr", err_orphan_rsp, 0);
    chk("t6_idle_write", dn_write, 1);
    chk("t6_idle_addr", dn_address, 64'hF0);
    chk("t6_idle_wait0", rq0_waitrequest, 0);
    tick();
    rq0_write = 1'b0;

    // Randomized traffic against a queue model
    do_reset();
    begin
      typedef struct { bit id; int len; } tag_s;
      tag_s q[$];
      int   head_beats;
      bit   last_srv;
      bit   act [2];
      bit   isrd [2];
      int   blen [2];
      logic [ADDR_W-1:0] addr [2];
      bit   any, g, blk, rsp, hid;
      head_beats = 0;
      last_srv = 1'b1;
      act = '{0, 0};
      isrd = '{0, 0};
      blen = '{1, 1};
      addr = '{'0, '0};
      cyc = 0;
      while (cyc < 1500 && (cyc < 400 || q.size() != 0 || act[0] || act[1])) begin
        for (int r = 0; r < 2; r++) begin
          if (cyc < 400 && !act[r] && $urandom_range(0, 2) == 0) begin
            act[r]  = 1'b1;
            isrd[r] = ($urandom_range(0, 3) != 0);
            blen[r] = isrd[r] ? int'($urandom_range(1, 4)) : 1;
            addr[r] = {$urandom, $urandom};
          end
        end
        rq0_read = act[0] & isrd[0]; rq0_write = act[0] & !isrd[0];
        rq1_read = act[1] & isrd[1]; rq1_write = act[1] & !isrd[1];
        rq0_burstcount = BW'(blen[0]); rq1_burstcount = BW'(blen[1]);
        rq0_address = addr[0]; rq1_address = addr[1];
        rq0_writedata = rand_data(); rq1_writedata = rand_data();
        dn_waitrequest = ($urandom_range(0, 3) == 0);
        rsp = (q.size() != 0) && ($urandom_range(0, 9) < 7);
        dn_readdatavalid = rsp;
        d = rand_data();
        dn_readdata = d;
        settle();

        any = act[0] | act[1];
        g   = (act[0] && act[1]) ? !last_srv : act[1];
        blk = any && isrd[g] && (q.size() >= DEPTH);
        hid = rsp ? q[0].id : 1'b0;
        chk("r_dn_read", dn_read, any && isrd[g] && !blk);
        chk("r_dn_write", dn_write, any && !isrd[g]);
        if (any) chk("r_addr", dn_address, addr[g]);
        chk("r_wait0", rq0_waitrequest, !(any && g == 0) || dn_waitrequest || blk);
        chk("r_wait1", rq1_waitrequest, !(any && g == 1) || dn_waitrequest || blk);
        chk("r_rdv0", rq0_readdatavalid, rsp && hid == 0);
        chk("r_rdv1", rq1_readdatavalid, rsp && hid == 1);
        if (rsp) chk("r_rdata", hid ? rq1_readdata : rq0_readdata, d);

        if (rsp) begin
          head_beats++;
          if (head_beats == q[0].len) begin
            void'(q.pop_front());
            head_beats = 0;
          end
        end
        if (any && !blk && !dn_waitrequest) begin
          last_srv = g;
          if (isrd[g]) q.push_back('{id: g, len: blen[g]});
          act[g] = 1'b0;
        end
        tick();
        cyc++;
      end
      chk("r_drained", q.size(), 0);
    end
    idle_inputs();
    settle();
    chk("r_err", err_orphan_rsp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
